// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multicycle unsigned ALU: single-cycle ADD/SUB/MUL, WIDTH-cycle restoring DIV/MOD
module multicycle_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal,
    output logic             busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state, state_next;

    logic [2:0]       op_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [CW-1:0]    count_r;

    logic             accept;
    logic             div_start;
    logic             last_step;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   imm_result;
    logic               imm_carry;
    logic               imm_dbz;
    logic               imm_illegal;

    assign accept    = in_valid && in_ready;
    assign div_start = ((opcode == OP_DIV) || (opcode == OP_MOD)) && (operand2 != '0);
    assign last_step = (state == EXEC) && (count_r == LAST_STEP);

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = div_start ? EXEC : DONE;
            EXEC: if (last_step) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
    always_comb begin
        shifted = {rem_r, quo_r[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_r};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        sum         = {1'b0, operand1} + {1'b0, operand2};
        prod        = {{WIDTH{1'b0}}, operand1} * {{WIDTH{1'b0}}, operand2};
        imm_result  = '0;
        imm_carry   = 1'b0;
        imm_dbz     = 1'b0;
        imm_illegal = 1'b0;
        case (opcode)
            OP_ADD: begin
                imm_result = sum[WIDTH-1:0];
                imm_carry  = sum[WIDTH];
            end
            OP_SUB: begin
                imm_result = operand1 - operand2;
                imm_carry  = operand1 < operand2;
            end
            OP_MUL: begin
                imm_result = prod[WIDTH-1:0];
                imm_carry  = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                imm_result = '1;
                imm_dbz    = (operand2 == '0);
            end
            OP_MOD: begin
                imm_result = operand1;
                imm_dbz    = (operand2 == '0);
            end
            default: imm_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_r        <= '0;
            divisor_r   <= '0;
            quo_r       <= '0;
            rem_r       <= '0;
            count_r     <= '0;
            result      <= '0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            illegal     <= 1'b0;
        end else if (accept) begin
            op_r        <= opcode;
            divisor_r   <= operand2;
            quo_r       <= operand1;
            rem_r       <= '0;
            count_r     <= '0;
            result      <= imm_result;
            carry       <= imm_carry;
            zero        <= (imm_result == '0);
            div_by_zero <= imm_dbz;
            illegal     <= imm_illegal;
        end else if (state == EXEC) begin
            quo_r   <= quo_next;
            rem_r   <= rem_next;
            count_r <= count_r + CW'(1);
            if (last_step) begin
                result      <= (op_r == OP_DIV) ? quo_next : rem_next;
                zero        <= ((op_r == OP_DIV) ? quo_next : rem_next) == '0;
                carry       <= 1'b0;
                div_by_zero <= 1'b0;
                illegal     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed and random scoreboard bench for multicycle_alu
module tb_multicycle_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         div_by_zero;
    logic         illegal;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         d;
        logic         i;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_n;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry(carry), .zero(zero), .div_by_zero(div_by_zero),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] op, input int a, input int b);
        exp_t e;
        int   r;
        e = '0;
        r = 0;
        case (op)
            3'd0: begin r = (a + b) % 256; e.c = (a + b) > 255; end
            3'd1: begin r = (a - b + 256) % 256; e.c = a < b; end
            3'd2: begin r = (a * b) % 256; e.c = (a * b) > 255; end
            3'd3: begin if (b == 0) begin r = 255; e.d = 1'b1; end else r = a / b; end
            3'd4: begin if (b == 0) begin r = a; e.d = 1'b1; end else r = a % b; end
            default: begin r = 0; e.i = 1'b1; end
        endcase
        e.res = r[W-1:0];
        e.z   = (r == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic send(input logic [2:0] op, input int a, input int b);
        opcode   = op;
        operand1 = a[W-1:0];
        operand2 = b[W-1:0];
        in_valid = 1'b1;
        check("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, {24'd0, result}, {24'd0, e.res});
            check({tag, "_carry"}, {31'd0, carry}, {31'd0, e.c});
            check({tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
            check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.d});
            check({tag, "_illegal"}, {31'd0, illegal}, {31'd0, e.i});
        end
    endtask

    // Waits for out_valid, checks latency and payload, completes handshake; ends at a negedge.
    task automatic recv(input string tag, input int exp_lat);
        int lat;
        lat    = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
        end while (!out_valid && lat < 50);
        check({tag, "_latency"}, lat, exp_lat);
        compare_pop(tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_after"}, {30'd0, busy, in_ready}, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        opcode    = '0;
        operand1  = '0;
        operand2  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_outputs", {19'd0, out_valid, busy, result, carry, zero, div_by_zero, illegal}, 32'd0);
        reset = 1'b0;
        #1 check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        send(3'd0, 200, 100); recv("add_200_100", 1);
        send(3'd1, 5, 7);     recv("sub_5_7", 1);
        send(3'd2, 16, 16);   recv("mul_16_16", 1);
        send(3'd2, 15, 17);   recv("mul_15_17", 1);
        send(3'd3, 100, 7);   recv("div_100_7", 9);
        check("div_busy_cycles", busy_n, 9);
        send(3'd4, 100, 7);   recv("mod_100_7", 9);
        send(3'd3, 255, 1);   recv("div_255_1", 9);
        send(3'd3, 42, 0);    recv("div_42_0", 1);
        send(3'd4, 42, 0);    recv("mod_42_0", 1);
        send(3'd6, 9, 9);     recv("illegal_110", 1);

        out_ready = 1'b0;
        send(3'd0, 1, 2);
        @(negedge clk);
        check("hold_out_valid_first", {31'd0, out_valid}, 32'd1);
        opcode   = 3'd2;
        operand1 = 8'd7;
        operand2 = 8'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_state", {22'd0, out_valid, in_ready, result}, {22'd0, 1'b1, 1'b0, 8'd3});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        compare_pop("hold_add_1_2");
        @(posedge clk);
        @(negedge clk);
        check("hold_release_idle", {29'd0, out_valid, busy, in_ready}, 32'd1);
        send(3'd0, 9, 9);     recv("back_to_back", 1);

        for (int k = 0; k < 16; k++) begin
            logic [2:0] op;
            int a, b;
            op = 3'($urandom_range(0, 4));
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            send(op, a, b);
            recv("random", ((op == 3'd3 || op == 3'd4) && b != 0) ? 9 : 1);
        end

        opcode   = 3'd3;
        operand1 = 8'd200;
        operand2 = 8'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_exec_busy", {30'd0, busy, out_valid}, 32'd2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_outputs", {19'd0, out_valid, busy, result, carry, zero, div_by_zero, illegal}, 32'd0);
        check("abort_in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1 check("abort_in_ready_after", {31'd0, in_ready}, 32'd1);
        begin
            int ov_seen;
            ov_seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (out_valid) ov_seen++;
            end
            check("abort_no_out_valid", ov_seen, 0);
        end
        send(3'd0, 3, 4);     recv("add_after_abort", 1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 4..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 in_valid  input  1  request present on opcode/operand1/operand2.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 opcode  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101-111 illegal.
REQ-007 operand1  input  WIDTH  first operand, unsigned.
REQ-008 operand2  input  WIDTH  second operand, unsigned.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 result  output  WIDTH  operation result.
REQ-012 carry  output  1  ADD carry-out / SUB borrow / MUL overflow; 0 otherwise.
REQ-013 zero  output  1  result == 0.
REQ-014 div_by_zero  output  1  DIV/MOD issued with operand2 == 0.
REQ-015 illegal  output  1  opcode 101-111 issued.
REQ-016 busy  output  1  high in every state other than IDLE.

Function
REQ-017 FSM states IDLE, EXEC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 Accept = in_valid && in_ready; opcode and operands captured into internal registers on accept; inputs ignored at all other times.
REQ-019 ADD/SUB/MUL/illegal/div-by-zero: IDLE -> DONE on accept; out_valid asserts the cycle after accept (latency 1).
REQ-020 DIV/MOD with operand2 != 0: IDLE -> EXEC on accept; restoring shift-subtract divider, one quotient bit per cycle, exactly WIDTH cycles in EXEC, then DONE; out_valid asserts WIDTH+1 cycles after accept.
REQ-021 ADD: result = (operand1 + operand2) mod 2^WIDTH, carry = bit WIDTH of the full sum.
REQ-022 SUB: result = (operand1 - operand2) mod 2^WIDTH, carry = 1 iff operand1 < operand2.
REQ-023 MUL: result = low WIDTH bits of the 2*WIDTH product, carry = 1 iff any upper WIDTH bits nonzero.
REQ-024 DIV: result = floor(operand1/operand2); MOD: result = operand1 mod operand2; carry = 0.
REQ-025 Division by zero: DIV result = all ones, MOD result = operand1, div_by_zero = 1, carry = 0.
REQ-026 Illegal opcode: result = 0, illegal = 1, carry = 0, zero = 1.
REQ-027 zero computed from final result for every operation; div_by_zero and illegal are 0 unless REQ-025/REQ-026 apply.
REQ-028 DONE: result and all flags held stable while out_valid && !out_ready; DONE -> IDLE on out_valid && out_ready.
REQ-029 No new request accepted in the handshake cycle that leaves DONE; earliest next accept is the following cycle.
REQ-030 Outputs result/flags are registered; no combinational path from operand or opcode inputs to any output.

Reset
REQ-031 reset high: state = IDLE, in_ready = 1 (when reset low), out_valid = 0, busy = 0, result = 0, carry = zero = div_by_zero = illegal = 0, divider registers cleared.
REQ-032 reset takes priority over all other events, including in_valid, out_ready and in-progress EXEC; aborted operation produces no output.
REQ-033 in_ready = 0 while reset is high; first accept possible on the cycle after reset deasserts.

Verification (WIDTH = 8)
REQ-034 ADD 200 + 100, out_ready=1 -> one cycle later out_valid=1, result=44, carry=1, zero=0.
REQ-035 SUB 5 - 7 -> result=254, carry=1; MUL 16 * 16 -> result=0, carry=1, zero=1; MUL 15 * 17 -> result=255, carry=0.
REQ-036 DIV 100 / 7 -> busy for 9 cycles, out_valid 9 cycles after accept, result=14; MOD 100 % 7 -> result=2; DIV 255 / 1 -> 255.
REQ-037 DIV 42 / 0 -> latency 1, result=255, div_by_zero=1; MOD 42 % 0 -> result=42, div_by_zero=1; opcode 110 -> result=0, illegal=1.
REQ-038 ADD 1 + 2 with out_ready=0 for 5 cycles -> result=3 held stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, back-to-back request accepted one cycle later.
REQ-039 DIV 200 / 3 accepted, reset pulsed on 4th EXEC cycle -> out_valid never asserts, all outputs 0, in_ready=1 cycle after reset drops; following ADD 3 + 4 -> result=7.
